sensor_drain_sched: RTL
=======================

Name: sensor_drain_sched

Overview:
- Round-robin read scheduler that shares one downstream stream port among NUM_CH sensor streaming FIFOs.
- Each FIFO has a registered 1-cycle read, registered full/empty flags, and overwrites its oldest entry when full.
- The block grants one FIFO at a time and drains up to BURST_LEN words from it.
- Each word goes out on a valid/ready stream tagged with the channel id and a burst-last flag, ahead of the packetiser/host interface.

Parameters:
- NUM_CH, 4, number of FIFO channels.
- CH_W, 2, width of the channel id; equals log2(NUM_CH).
- DATA_WIDTH, 8, word width, matching the FIFO DATA_WIDTH.
- BURST_LEN, 8, maximum words per grant (1..2^BEAT_W-1).
- BEAT_W, 4, width of the beat counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low; clock is clk.
- ch_en  in  NUM_CH  per-channel drain enable.
- fifo_empty  in  NUM_CH  empty flags from the FIFOs.
- fifo_rd_data  in  NUM_CH*DATA_WIDTH  concatenated rd_data; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- fifo_rd_en  out  NUM_CH  read strobes, at most one bit high at a time.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  output word.
- m_ch  out  CH_W  source channel of m_data.
- m_last  out  1  marks the final word of the current grant.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset values: fifo_rd_en=0, m_valid=0, m_data=0, m_ch=0, m_last=0, busy=0, state=IDLE, beat=0, rr_ptr=NUM_CH-1 (so channel 0 wins first).
- Reset mid-operation aborts with no flush. Any latched word is dropped. The FIFO-side read already performed is not undone.
- FSM states: IDLE, ISSUE, CAPTURE, SETTLE, SEND.
- IDLE:
  - cand = ch_en & ~fifo_empty.
  - If cand==0, stay in IDLE.
  - Otherwise grant the first set bit of cand searching from rr_ptr+1 upward, wrapping modulo NUM_CH.
  - Latch grant into gnt and m_ch, clear beat, go to ISSUE.
- ISSUE: fifo_rd_en[gnt]=1 for exactly this one cycle, then go to CAPTURE.
- CAPTURE:
  - FIFO rd_data is valid this cycle.
  - Latch fifo_rd_data slice gnt into m_data, beat<=beat+1, go to SETTLE.
- SETTLE:
  - The FIFO empty flag lags a read by 2 edges, so fifo_empty[gnt] reflects the read in this cycle.
  - m_last <= (beat==BURST_LEN) | fifo_empty[gnt] | ~ch_en[gnt].
  - m_valid<=1, go to SEND.
- SEND:
  - Hold m_data, m_ch and m_last stable while m_valid & ~m_ready. No fifo_rd_en is issued during backpressure.
  - On m_valid & m_ready: m_valid<=0.
  - If m_last: rr_ptr<=gnt, go to IDLE.
  - Else go to ISSUE (same channel).
- Throughput:
  - Minimum 4 cycles per word (ISSUE, CAPTURE, SETTLE, SEND with m_ready=1).
  - rd_en pulses on one channel are never closer than 4 cycles. This guarantees the FIFO's registered empty is never stale at issue.
- Burst length:
  - A grant delivers 1..BURST_LEN words.
  - m_last is set on exactly one word per grant and is never set on a word that is not the last one issued.
- Round-robin fairness: after a grant to channel k, every other requesting channel is served before k is granted again.
- ch_en deasserted mid-burst: the word already read is still delivered, with m_last=1. The channel is not issued again until ch_en returns high.
- ch_en deasserted in IDLE: the channel is ignored for arbitration.
- FIFO overflow: FIFO overwrites while a grant is in progress are transparent to this block. The block never asserts rd_en when fifo_empty[gnt] was 1 at SETTLE.
- Never more than one fifo_rd_en bit high. fifo_rd_en is 0 outside ISSUE.
- busy=1 from the cycle after the IDLE grant until the cycle after the last handshake.

Test Plan:
- Ch0 holds 3 words (0xA1,0xA2,0xA3), others empty, m_ready=1 -> 3 beats on m_ch=0 in order. m_last only on 0xA3. rd_en[0] pulses spaced 4 cycles. Back to IDLE, busy=0.
- All 4 channels hold 20 words each, BURST_LEN=8, m_ready=1 -> grant order 0,1,2,3,0,1,2,3,0,1,2,3. Bursts are 8,8,8,8,8,8,8,8,4,4,4,4 words. m_last on the 8th/4th word of each burst.
- m_ready held low 10 cycles during SEND -> m_valid, m_data, m_ch and m_last constant. No fifo_rd_en during the stall. Flow resumes on m_ready=1 with no word lost or duplicated.
- Ch1 holds 10 words. ch_en[1] cleared during the CAPTURE of word 3 -> word 3 sent with m_last=1. Ch1 is not granted afterwards while ch0 and ch2 with data are served.
- rst_n low for 1 cycle while in SEND on ch2 -> next cycle m_valid=0, fifo_rd_en=0, busy=0. First grant after reset goes to ch0 if it has data.
- All fifo_empty=1 or ch_en=0 for 50 cycles -> fifo_rd_en stays 0, m_valid stays 0, busy stays 0.

Source files
------------

// File: rtl/sensor_drain_sched.sv
// Round-robin drain scheduler: grants one sensor FIFO at a time, reads up to
// BURST_LEN words from it and forwards each on a tagged valid/ready stream.
module sensor_drain_sched #(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 8,
  parameter int BEAT_W     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [NUM_CH-1:0]            fifo_empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_rd_data,
  output logic [NUM_CH-1:0]            fifo_rd_en,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [CH_W-1:0]              m_ch,
  output logic                         m_last,
  output logic                         busy
);

  // Stream handshake: a word transfers on any edge where m_valid & m_ready;
  // m_data/m_ch/m_last stay stable while m_valid is high and m_ready is low.

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, SETTLE, SEND} state_t;

  state_t              state;
  logic [CH_W-1:0]     gnt;
  logic [CH_W-1:0]     rr_ptr;
  logic [BEAT_W-1:0]   beat;
  logic [NUM_CH-1:0]   cand;
  logic [CH_W-1:0]     pick;
  logic [NUM_CH-1:0]   pick_oh;
  logic [NUM_CH-1:0]   gnt_oh;

  // Scan downward so the nearest requester after rr_ptr is the final writer.
  always_comb begin
    cand    = ch_en & ~fifo_empty;
    pick    = '0;
    pick_oh = '0;
    gnt_oh  = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (cand[(int'(rr_ptr) + i) % NUM_CH]) begin
        pick = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      end
    end
    pick_oh[pick] = 1'b1;
    gnt_oh[gnt]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      rr_ptr     <= CH_W'(NUM_CH - 1);
      beat       <= '0;
      fifo_rd_en <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_ch       <= '0;
      m_last     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|cand) begin
            gnt        <= pick;
            m_ch       <= pick;
            beat       <= '0;
            fifo_rd_en <= pick_oh;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          fifo_rd_en <= '0;
          state      <= CAPTURE;
        end
        CAPTURE: begin
          m_data <= fifo_rd_data[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
          beat   <= beat + 1'b1;
          state  <= SETTLE;
        end
        SETTLE: begin
          // The empty flag now includes the read just performed.
          m_last  <= (beat == BEAT_W'(BURST_LEN)) | fifo_empty[gnt] | ~ch_en[gnt];
          m_valid <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (m_last) begin
              rr_ptr <= gnt;
              busy   <= 1'b0;
              state  <= IDLE;
            end else begin
              fifo_rd_en <= gnt_oh;
              state      <= ISSUE;
            end
          end
        end
        default: begin
          fifo_rd_en <= '0;
          m_valid    <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
